cache_writeback_unit: RTL and testbench

- Eviction-side reader of the 4-way, 128-set, 512-bit-line cache data array.
- On a dirty-victim eviction request it captures the selected way's line from the array read buses in one cycle.
- It then streams the line to main memory as sequential 32-bit write beats over a valid/ready interface.
- It pulses a completion strobe to the cache controller when the final beat is accepted.

---
 rtl/cache_writeback_unit.sv | 127 ++++++++++++
 tb/tb_cache_writeback_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_writeback_unit.sv
// Dirty-victim write-back: captures one cache line and streams it to memory as 32-bit beats.
// Optional even-parity output on the beat data is enabled by defining WB_PARITY_EN.
module cache_writeback_unit #(
  parameter int unsigned TAG_WIDTH   = 19,
  parameter int unsigned INDEX_WIDTH = 7,
  parameter int unsigned BLOCK_SIZE  = 512,
  parameter int unsigned WORD_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   evict_req,
  output logic                   evict_ready,
  input  logic [1:0]             evict_way,
  input  logic [INDEX_WIDTH-1:0] evict_index,
  input  logic [TAG_WIDTH-1:0]   evict_tag,
  input  logic [BLOCK_SIZE-1:0]  line_0,
  input  logic [BLOCK_SIZE-1:0]  line_1,
  input  logic [BLOCK_SIZE-1:0]  line_2,
  input  logic [BLOCK_SIZE-1:0]  line_3,
  output logic                   mem_wr_valid,
  input  logic                   mem_wr_ready,
  output logic [31:0]            mem_wr_addr,
  output logic [WORD_WIDTH-1:0]  mem_wr_data,
  output logic                   mem_wr_last,
  output logic                   wb_done,
`ifdef WB_PARITY_EN
  output logic                   mem_wr_parity,
`endif
  output logic                   busy
);

  localparam int unsigned BEATS    = BLOCK_SIZE / WORD_WIDTH;
  localparam int unsigned BEAT_W   = $clog2(BEATS);
  localparam int unsigned OFFSET_W = $clog2(BLOCK_SIZE / 8);
  localparam logic [BEAT_W-1:0] LastBeat = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  state_e                state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [BLOCK_SIZE-1:0] buf_q, buf_d;
  logic [31:0]           base_q, base_d;
  logic [BLOCK_SIZE-1:0] sel_line;

  always_comb begin
    sel_line = line_0;
    unique case (evict_way)
      2'd0: sel_line = line_0;
      2'd1: sel_line = line_1;
      2'd2: sel_line = line_2;
      2'd3: sel_line = line_3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      beat_q  <= '0;
      buf_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      buf_q   <= buf_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    buf_d        = buf_q;
    base_d       = base_q;
    evict_ready  = 1'b0;
    mem_wr_valid = 1'b0;
    mem_wr_addr  = '0;
    mem_wr_data  = '0;
    mem_wr_last  = 1'b0;
    wb_done      = 1'b0;
    busy         = 1'b0;
    unique case (state_q)
      StIdle: begin
        evict_ready = 1'b1;
        if (evict_req) begin
          // The array index is only held during this cycle, so the whole line is taken now.
          buf_d   = sel_line;
          base_d  = 32'({evict_tag, evict_index, OFFSET_W'(0)});
          beat_d  = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        busy         = 1'b1;
        mem_wr_valid = 1'b1;
        mem_wr_data  = buf_q[beat_q * WORD_WIDTH +: WORD_WIDTH];
        mem_wr_addr  = base_q + 32'(beat_q) * 32'(WORD_WIDTH / 8);
        mem_wr_last  = (beat_q == LastBeat);
        if (mem_wr_ready) begin
          if (beat_q == LastBeat) state_d = StDone;
          else                    beat_d  = beat_q + 1'b1;
        end
      end
      StDone: begin
        busy    = 1'b1;
        wb_done = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Outputs show their reset values while reset is held, whatever the registered state.
    if (reset) begin
      evict_ready  = 1'b1;
      mem_wr_valid = 1'b0;
      mem_wr_addr  = '0;
      mem_wr_data  = '0;
      mem_wr_last  = 1'b0;
      wb_done      = 1'b0;
      busy         = 1'b0;
    end
  end

`ifdef WB_PARITY_EN
  // Data is forced to zero when no beat is valid, so parity is zero then too.
  assign mem_wr_parity = ^mem_wr_data;
`endif

endmodule

// File: tb/tb_cache_writeback_unit.sv
// Directed bench for cache_writeback_unit: full transfers, stalls, held requests, mid-line reset.
// Parity checks are included when WB_PARITY_EN is defined.
module tb_cache_writeback_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic         evict_req;
  logic         evict_ready;
  logic [1:0]   evict_way;
  logic [6:0]   evict_index;
  logic [18:0]  evict_tag;
  logic [511:0] ln [4];
  logic         mem_wr_valid;
  logic         mem_wr_ready;
  logic [31:0]  mem_wr_addr;
  logic [31:0]  mem_wr_data;
  logic         mem_wr_last;
  logic         wb_done;
  logic         busy;
`ifdef WB_PARITY_EN
  logic         mem_wr_parity;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cache_writeback_unit dut (
    .clk          (clk),
    .reset        (reset),
    .evict_req    (evict_req),
    .evict_ready  (evict_ready),
    .evict_way    (evict_way),
    .evict_index  (evict_index),
    .evict_tag    (evict_tag),
    .line_0       (ln[0]),
    .line_1       (ln[1]),
    .line_2       (ln[2]),
    .line_3       (ln[3]),
    .mem_wr_valid (mem_wr_valid),
    .mem_wr_ready (mem_wr_ready),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_last  (mem_wr_last),
    .wb_done      (wb_done),
`ifdef WB_PARITY_EN
    .mem_wr_parity(mem_wr_parity),
`endif
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] w0, input logic [31:0] w1,
                      input logic [31:0] w2, input logic [31:0] w3);
    for (int k = 0; k < 16; k++) begin
      ln[0][k*32 +: 32] = w0;
      ln[1][k*32 +: 32] = w1;
      ln[2][k*32 +: 32] = w2;
      ln[3][k*32 +: 32] = w3;
    end
  endtask

  // stall=1 drives ready with the repeating pattern 1,0,0. hold=1 keeps evict_req high on the
  // other way during the transfer so the next call's request is already pending.
  task automatic transfer(input logic [1:0] way, input logic [6:0] idx, input logic [18:0] tag,
                          input bit stall, input bit hold);
    logic [511:0] cap;
    logic [511:0] saved [4];
    logic [31:0]  base;
    logic [31:0]  ew;
    int           beat;
    int           cyc;
    cap  = ln[way];
    base = {tag, idx, 6'b0};
    for (int i = 0; i < 4; i++) saved[i] = ln[i];
    evict_req   = 1'b1;
    evict_way   = way;
    evict_index = idx;
    evict_tag   = tag;
    chk("idle_ready", {31'b0, evict_ready}, 32'd1);
    chk("idle_busy", {31'b0, busy}, 32'd0);
    step();
    // The array no longer holds this line; any re-read would show inverted data.
    for (int i = 0; i < 4; i++) ln[i] = ~ln[i];
    evict_req   = hold;
    evict_way   = way ^ 2'd1;
    evict_index = idx + 7'd1;
    beat = 0;
    cyc  = 0;
    while (beat < 16 && cyc < 100) begin
      mem_wr_ready = stall ? ((cyc % 3) == 0) : 1'b1;
      ew = cap[beat*32 +: 32];
      chk("valid", {31'b0, mem_wr_valid}, 32'd1);
      chk("addr", mem_wr_addr, base + 32'(beat * 4));
      chk("data", mem_wr_data, ew);
      chk("last", {31'b0, mem_wr_last}, {31'b0, beat == 15});
      chk("send_done", {31'b0, wb_done}, 32'd0);
      chk("send_ready", {31'b0, evict_ready}, 32'd0);
`ifdef WB_PARITY_EN
      chk("parity", {31'b0, mem_wr_parity}, {31'b0, ^ew});
`endif
      step();
      if (mem_wr_ready) beat++;
      cyc++;
    end
    chk("beat_budget", 32'(beat), 32'd16);
    mem_wr_ready = 1'b1;
    chk("done_pulse", {31'b0, wb_done}, 32'd1);
    chk("done_valid", {31'b0, mem_wr_valid}, 32'd0);
    chk("done_ready", {31'b0, evict_ready}, 32'd0);
    chk("done_busy", {31'b0, busy}, 32'd1);
    for (int i = 0; i < 4; i++) ln[i] = saved[i];
    evict_index = idx;
    step();
    chk("post_done", {31'b0, wb_done}, 32'd0);
    chk("post_ready", {31'b0, evict_ready}, 32'd1);
    chk("post_busy", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    evict_req    = 1'b0;
    evict_way    = 2'd0;
    evict_index  = 7'd0;
    evict_tag    = 19'd0;
    mem_wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) ln[i] = '0;
    step();
    step();
    chk("rst_ready", {31'b0, evict_ready}, 32'd1);
    chk("rst_valid", {31'b0, mem_wr_valid}, 32'd0);
    chk("rst_last", {31'b0, mem_wr_last}, 32'd0);
    chk("rst_done", {31'b0, wb_done}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_addr", mem_wr_addr, 32'd0);
    chk("rst_data", mem_wr_data, 32'd0);

    // A request coincident with reset must not be captured.
    evict_req = 1'b1;
    evict_way = 2'd1;
    step();
    chk("rst_req_busy", {31'b0, busy}, 32'd0);
    chk("rst_req_valid", {31'b0, mem_wr_valid}, 32'd0);
    evict_req = 1'b0;
    reset     = 1'b0;
    step();

    // Way 2, index 5, tag 0x1234A: base 0x2469_4140, words 0xA000_0000 + k.
    fill(32'h0, 32'h1111_1111, 32'h0, 32'h3333_3333);
    for (int k = 0; k < 16; k++) ln[2][k*32 +: 32] = 32'hA000_0000 + 32'(k);
    chk("base_addr_check", {19'h1234A, 7'h05, 6'b0}, 32'h2469_4140);
    transfer(2'd2, 7'h05, 19'h1234A, 1'b0, 1'b0);
    transfer(2'd2, 7'h05, 19'h1234A, 1'b1, 1'b0);

    // Held request on way 3 is only taken once the first line has finished.
    transfer(2'd2, 7'h05, 19'h1234A, 1'b0, 1'b1);
    transfer(2'd3, 7'h05, 19'h1234A, 1'b0, 1'b0);

    // Reset after beat 7 is accepted: line is dropped, no completion strobe.
    evict_req   = 1'b1;
    evict_way   = 2'd1;
    evict_index = 7'h7F;
    evict_tag   = 19'h7FFFF;
    step();
    evict_req = 1'b0;
    for (int b = 0; b < 8; b++) begin
      chk("pre_rst_data", mem_wr_data, 32'h1111_1111);
      chk("pre_rst_addr", mem_wr_addr, 32'hFFFF_FFC0 + 32'(b * 4));
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_valid", {31'b0, mem_wr_valid}, 32'd0);
    chk("abort_done", {31'b0, wb_done}, 32'd0);
    chk("abort_ready", {31'b0, evict_ready}, 32'd1);
    step();
    chk("abort_done2", {31'b0, wb_done}, 32'd0);
    chk("abort_idle", {31'b0, mem_wr_valid}, 32'd0);
    transfer(2'd0, 7'h11, 19'h00ABC, 1'b0, 1'b0);

    // Distinct patterns per way.
    fill(32'h0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
    for (int w = 0; w < 4; w++) transfer(2'(w), 7'(w + 3), 19'(w * 5 + 1), 1'b0, 1'b0);

    // Odd-weight word to exercise a set parity bit.
    ln[0][31:0] = 32'h0000_0001;
    transfer(2'd0, 7'h00, 19'h00001, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
